// File: rtl/y86_cc_unit_if.sv
// y86_cc_unit_if: handshake/bus bundle for the Y86-64 condition-code unit.
//   master : execute-side producer of ALU results and condition queries
//   slave  : the condition-code unit itself
interface y86_cc_unit_if;
    // ALU result update channel
    logic        upd_valid;
    logic        upd_ready;
    logic [63:0] upd_val;
    logic        upd_ovf;
    logic        upd_setcc;
    logic        upd_exc;
    // condition query channel
    logic        q_valid;
    logic        q_ready;
    logic [3:0]  q_ifun;
    // query response (no backpressure)
    logic        r_valid;
    logic        r_cnd;
    logic        r_err;
    // status
    logic [2:0]  cc_o;
    logic        frozen_o;

    modport master (
        output upd_valid, upd_val, upd_ovf, upd_setcc, upd_exc,
        output q_valid, q_ifun,
        input  upd_ready, q_ready,
        input  r_valid, r_cnd, r_err, cc_o, frozen_o
    );

    modport slave (
        input  upd_valid, upd_val, upd_ovf, upd_setcc, upd_exc,
        input  q_valid, q_ifun,
        output upd_ready, q_ready,
        output r_valid, r_cnd, r_err, cc_o, frozen_o
    );
endinterface

// File: rtl/y86_cc_unit.sv
// y86_cc_unit: Y86-64 condition-code register and jXX/cmovXX evaluator.
// ALU results arrive on the update channel; setcc results are captured in a
// one-deep pending register and committed on the following cycle. Queries
// get a registered one-cycle response pulse. An excepting instruction
// freezes the flags until reset.
// Optional feature macro: CC_BYPASS_EN -- when defined, queries are accepted
// while an update is pending and evaluated against the forwarded pending
// flags instead of stalling for one cycle.
module y86_cc_unit (
    input  logic                clk,
    input  logic                rst,
    y86_cc_unit_if.slave        bus
);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        PEND   = 2'd1,
        FROZEN = 2'd2
    } state_t;

    // flag vector layout {ZF,SF,OF}
    localparam logic [2:0] CC_RESET = 3'b100;

    state_t      r_state;
    state_t      w_state_nxt;

    logic [2:0]  r_cc;
    logic [2:0]  r_pcc;
    logic        r_rsp_valid;
    logic        r_rsp_cnd;
    logic        r_rsp_err;

    logic        w_upd_ready;
    logic        w_q_ready;
    logic        w_upd_fire;
    logic        w_q_fire;
    logic        w_load_pcc;
    logic        w_commit;
    logic [2:0]  w_new_flags;
    logic [2:0]  w_q_src;
    logic        w_q_cnd;
    logic        w_q_err;

    // Evaluate a Y86 condition function against a {ZF,SF,OF} flag vector.
    // Illegal codes evaluate false; legality is reported separately.
    function automatic logic f_cond(input logic [3:0] ifun, input logic [2:0] cc);
        logic zf;
        logic x;
        zf = cc[2];
        x  = cc[1] ^ cc[0];
        case (ifun)
            4'd0:    f_cond = 1'b1;
            4'd1:    f_cond = x | zf;
            4'd2:    f_cond = x;
            4'd3:    f_cond = zf;
            4'd4:    f_cond = ~zf;
            4'd5:    f_cond = ~x;
            4'd6:    f_cond = ~x & ~zf;
            default: f_cond = 1'b0;
        endcase
    endfunction

    assign w_upd_fire  = bus.upd_valid & w_upd_ready;
    assign w_q_fire    = bus.q_valid & w_q_ready;

    // Flags derived straight from the offered ALU result.
    assign w_new_flags = {(bus.upd_val == 64'd0), bus.upd_val[63], bus.upd_ovf};

`ifdef CC_BYPASS_EN
    // In PEND the pending flags are the youngest architectural view, so a
    // query accepted there reads them directly.
    assign w_q_src = (r_state == PEND) ? r_pcc : r_cc;
`else
    // Queries are never accepted in PEND, so committed flags are always current.
    assign w_q_src = r_cc;
`endif

    // A same-cycle update in RUN lands in pcc, not cc, so the query sees
    // the older flags as program order requires.
    assign w_q_cnd = f_cond(bus.q_ifun, w_q_src);
    assign w_q_err = (bus.q_ifun > 4'd6);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic and state-decoded handshake readies.
    always_comb begin
        w_state_nxt = r_state;
        w_upd_ready = 1'b0;
        w_q_ready   = 1'b1;
        w_load_pcc  = 1'b0;
        w_commit    = 1'b0;
        case (r_state)
            RUN: begin
                w_upd_ready = 1'b1;
                if (w_upd_fire) begin
                    // an exception wins over setcc and never touches the flags
                    if (bus.upd_exc) begin
                        w_state_nxt = FROZEN;
                    end else if (bus.upd_setcc) begin
                        w_load_pcc  = 1'b1;
                        w_state_nxt = PEND;
                    end
                end
            end
            PEND: begin
                w_commit    = 1'b1;
                w_state_nxt = RUN;
`ifdef CC_BYPASS_EN
                w_q_ready   = 1'b1;
`else
                w_q_ready   = 1'b0;
`endif
            end
            FROZEN: begin
                // only reset leaves FROZEN; queries are still served
                w_state_nxt = FROZEN;
            end
            default: begin
                w_state_nxt = RUN;
            end
        endcase
    end

    // Pending and committed flag registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pcc <= 3'b000;
            r_cc  <= CC_RESET;
        end else begin
            if (w_load_pcc) begin
                r_pcc <= w_new_flags;
            end
            if (w_commit) begin
                r_cc <= r_pcc;
            end
        end
    end

    // Query response: one-cycle valid pulse, data held between pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rsp_valid <= 1'b0;
            r_rsp_cnd   <= 1'b0;
            r_rsp_err   <= 1'b0;
        end else begin
            r_rsp_valid <= w_q_fire;
            if (w_q_fire) begin
                r_rsp_cnd <= w_q_cnd;
                r_rsp_err <= w_q_err;
            end
        end
    end

    assign bus.upd_ready = w_upd_ready;
    assign bus.q_ready   = w_q_ready;
    assign bus.r_valid   = r_rsp_valid;
    assign bus.r_cnd     = r_rsp_cnd;
    assign bus.r_err     = r_rsp_err;
    assign bus.cc_o      = r_cc;
    assign bus.frozen_o  = (r_state == FROZEN);

endmodule

// File: tb/tb_y86_cc_unit.sv
// tb_y86_cc_unit: directed test-plan steps followed by randomized traffic,
// checked against a transaction-level model of the condition-code unit.
module tb_y86_cc_unit;

`ifdef CC_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk;
    logic rst;

    y86_cc_unit_if bus ();

    y86_cc_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // model state: architectural flags, pending flags, mode bits, response
    logic       m_zf, m_sf, m_of;
    logic       p_zf, p_sf, p_of;
    logic       m_pending;
    logic       m_frozen;
    logic       m_rvalid, m_rcnd, m_rerr;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference condition evaluation from the Y86 rules.
    function automatic logic ref_cond(input int ifun, input logic zf, input logic sf, input logic of_);
        logic lt;
        lt = (sf != of_);
        if (ifun == 0) return 1'b1;
        if (ifun == 1) return lt || zf;
        if (ifun == 2) return lt;
        if (ifun == 3) return zf;
        if (ifun == 4) return !zf;
        if (ifun == 5) return !lt;
        if (ifun == 6) return !lt && !zf;
        return 1'b0;
    endfunction

    task automatic idle_inputs();
        bus.upd_valid = 1'b0;
        bus.upd_val   = 64'd0;
        bus.upd_ovf   = 1'b0;
        bus.upd_setcc = 1'b0;
        bus.upd_exc   = 1'b0;
        bus.q_valid   = 1'b0;
        bus.q_ifun    = 4'd0;
    endtask

    task automatic check_outputs(input string ph);
        chk({ph, "_r_valid"}, 64'(bus.r_valid), 64'(m_rvalid));
        chk({ph, "_r_cnd"},   64'(bus.r_cnd),   64'(m_rcnd));
        chk({ph, "_r_err"},   64'(bus.r_err),   64'(m_rerr));
        chk({ph, "_cc_o"},    64'(bus.cc_o),    64'({m_zf, m_sf, m_of}));
        chk({ph, "_frozen"},  64'(bus.frozen_o), 64'(m_frozen));
    endtask

    // Reset for one cycle with a query offered, which must not produce a pulse.
    task automatic do_reset();
        idle_inputs();
        bus.q_valid = 1'b1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.q_valid = 1'b0;
        m_zf = 1'b1; m_sf = 1'b0; m_of = 1'b0;
        p_zf = 1'b0; p_sf = 1'b0; p_of = 1'b0;
        m_pending = 1'b0;
        m_frozen  = 1'b0;
        m_rvalid = 1'b0; m_rcnd = 1'b0; m_rerr = 1'b0;
        check_outputs("rst");
        chk("rst_upd_ready", 64'(bus.upd_ready), 64'd1);
        chk("rst_q_ready",   64'(bus.q_ready),   64'd1);
    endtask

    // One clock of traffic. Called #1 after a rising edge.
    task automatic step(input string ph, input logic uv, input logic [63:0] val,
                        input logic ovf, input logic setcc, input logic exc,
                        input logic qv, input logic [3:0] ifun);
        logic eu, eq, ufire, qfire;
        bus.upd_valid = uv;
        bus.upd_val   = val;
        bus.upd_ovf   = ovf;
        bus.upd_setcc = setcc;
        bus.upd_exc   = exc;
        bus.q_valid   = qv;
        bus.q_ifun    = ifun;
        eu = !m_pending && !m_frozen;
        eq = BYP || !m_pending;
        #1;
        chk({ph, "_upd_ready"}, 64'(bus.upd_ready), 64'(eu));
        chk({ph, "_q_ready"},   64'(bus.q_ready),   64'(eq));
        ufire = uv && eu;
        qfire = qv && eq;
        @(posedge clk);
        #1;
        // response uses the flags visible to the query before this update
        m_rvalid = qfire;
        if (qfire) begin
            if (m_pending) m_rcnd = ref_cond(int'(ifun), p_zf, p_sf, p_of);
            else           m_rcnd = ref_cond(int'(ifun), m_zf, m_sf, m_of);
            m_rerr = (ifun >= 4'd7);
        end
        if (m_pending) begin
            m_zf = p_zf; m_sf = p_sf; m_of = p_of;
            m_pending = 1'b0;
        end else if (ufire) begin
            if (exc) begin
                m_frozen = 1'b1;
            end else if (setcc) begin
                p_zf = (val == 64'd0);
                p_sf = val[63];
                p_of = ovf;
                m_pending = 1'b1;
            end
        end
        check_outputs(ph);
        idle_inputs();
    endtask

    task automatic idle(input string ph);
        step(ph, 1'b0, 64'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
    endtask

    task automatic query(input string ph, input logic [3:0] ifun);
        step(ph, 1'b0, 64'd0, 1'b0, 1'b0, 1'b0, 1'b1, ifun);
    endtask

    initial begin
        logic [63:0] rv;
        rst = 1'b1;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        // reset flags: equal holds
        query("tp1_q3", 4'd3);
        chk("tp1_cnd", 64'(bus.r_cnd), 64'd1);
        chk("tp1_cc",  64'(bus.cc_o),  64'h4);

        // negative result, no overflow -> less
        step("tp2_upd", 1'b1, 64'hFFFF_FFFF_FFFF_FFFB, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
        idle("tp2_commit");
        chk("tp2_cc", 64'(bus.cc_o), 64'h2);
        query("tp2_q2", 4'd2);
        chk("tp2_l", 64'(bus.r_cnd), 64'd1);
        query("tp2_q6", 4'd6);
        chk("tp2_g", 64'(bus.r_cnd), 64'd0);

        // query right after a setcc accept: stalls unless bypassed
        step("tp3_upd", 1'b1, 64'h8000_0000_0000_0000, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
        query("tp3_q5a", 4'd5);
        if (!BYP) query("tp3_q5b", 4'd5);
        chk("tp3_ge", 64'(bus.r_cnd), 64'd1);
        chk("tp3_rv", 64'(bus.r_valid), 64'd1);

        // same-cycle update and query: query sees old ZF=0
        step("tp4_both", 1'b1, 64'd0, 1'b0, 1'b1, 1'b0, 1'b1, 4'd4);
        chk("tp4_ne_old", 64'(bus.r_cnd), 64'd1);
        idle("tp4_commit");
        query("tp4_q4", 4'd4);
        chk("tp4_ne_new", 64'(bus.r_cnd), 64'd0);

        // exception freezes flags, queries still served
        step("tp5_exc", 1'b1, 64'd5, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0);
        chk("tp5_frozen", 64'(bus.frozen_o), 64'd1);
        chk("tp5_cc",     64'(bus.cc_o),     64'h4);
        step("tp5_blocked", 1'b1, 64'd7, 1'b0, 1'b1, 1'b0, 1'b1, 4'd3);
        chk("tp5_q3", 64'(bus.r_cnd), 64'd1);
        do_reset();

        // illegal function code
        query("tp6_q9", 4'd9);
        chk("tp6_err", 64'(bus.r_err), 64'd1);
        chk("tp6_cnd", 64'(bus.r_cnd), 64'd0);

        // reset while pending drops the update
        step("tp7_upd", 1'b1, 64'd5, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
        do_reset();
        idle("tp7_after");
        chk("tp7_cc", 64'(bus.cc_o), 64'h4);

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 39) == 0) begin
                do_reset();
            end else begin
                case ($urandom_range(0, 3))
                    0:       rv = 64'd0;
                    1:       rv = {1'b1, 31'($urandom), 32'($urandom)};
                    default: rv = {32'($urandom), 32'($urandom)};
                endcase
                step("rnd", 1'($urandom_range(0, 1)), rv, 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)), ($urandom_range(0, 29) == 0),
                     1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
